sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- MEM-stage data-memory front end: maps 32-bit word loads/stores onto an external 16-bit asynchronous SRAM (256K x 16) using two half-word accesses per word.
- Sits between the EXE stage register outputs and the MEM stage register.
- Produces mem_result (readData) and ready; ~ready drives the pipeline-wide SRAM_freeze.

Parameters:
- BASE_ADDR, 1024: CPU byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles each half-word access is held on the SRAM pins (range 1..15).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wr_en  input  1  store request from EXE stage register (MEM_W_EN).
- rd_en  input  1  load request from EXE stage register (MEM_R_EN).
- address  input  32  byte address (ALU result).
- writeData  input  32  store data (Val_Rm).
- readData  output  32  loaded word, to MEM stage register mem_result.
- ready  output  1  1 = no access in progress, pipeline may advance.
- misaligned  output  1  sticky alignment error flag (see Optional Feature).
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_UB_N, SRAM_LB_N  output  1 each  byte enables, active low.
- SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  write enable, chip enable, output enable, active low.

Behaviour:
- Address mapping: word = (address - BASE_ADDR) >> 2, modulo 2^32, truncated to 17 bits. Low half uses SRAM_ADDR = {word[16:0],1'b0}; high half uses {word[16:0],1'b1}.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- A 4-bit counter counts each LO/HI state up to WAIT_CYCLES. The FSM advances on the last count, and the counter clears on every state change.
- IDLE:
  - wr_en=1 -> WR_LO. wr_en has priority if wr_en and rd_en are both 1.
  - else rd_en=1 -> RD_LO.
  - else stay in IDLE.
- State sequence: WR_LO -> WR_HI -> DONE; RD_LO -> RD_HI -> DONE; DONE -> IDLE unconditionally after 1 cycle.
- ready (combinational):
  - 0 in IDLE while (wr_en|rd_en)=1.
  - 0 in every LO/HI state.
  - 1 in DONE.
  - 1 in IDLE with no request.
- The request stays asserted during DONE because the pipeline is still frozen on that cycle entry. DONE therefore never starts a new access, so each instruction causes exactly one access.
- Freeze length: ready is low for 1 + 2*WAIT_CYCLES cycles, then high for 1 cycle in DONE.
- Address and data are sampled each cycle from the inputs. Upstream holds them stable because of the freeze.
- Pin driving:
  - SRAM_CE_N = 0 in the LO/HI states, 1 otherwise.
  - SRAM_UB_N = SRAM_LB_N = 0 always.
  - SRAM_WE_N = 0 only in WR_LO/WR_HI.
  - SRAM_OE_N = 0 only in RD_LO/RD_HI.
  - SRAM_DQ carries writeData[15:0] in WR_LO and writeData[31:16] in WR_HI; it is high-Z in every other state.
- Read capture:
  - SRAM_DQ is latched into a low-half register on the last cycle of RD_LO.
  - On the last cycle of RD_HI, readData <= {SRAM_DQ, low_half}.
  - readData holds its value until the next read completes; writes do not change it.
- Reset (any time, including mid-access):
  - FSM -> IDLE, counter = 0, readData = 0, low-half register = 0, misaligned = 0.
  - ready = 1 if no request.
  - SRAM_WE_N = SRAM_CE_N = SRAM_OE_N = 1, SRAM_ADDR = 0, SRAM_DQ = high-Z.
  - An interrupted access is abandoned. After reset it restarts from IDLE if the request is still present.

Optional Feature:
- Macro: SRAM_MISALIGN_CHECK_EN.
- Defined: when a request is accepted in IDLE with address[1:0] != 2'b00, misaligned is set to 1 and stays 1 until reset. The access proceeds using the truncated word address.
- Undefined: misaligned is tied to 0 and there is no checking logic.

Test Plan:
- Reset with rst=0, no requests -> ready=1, readData=0, SRAM_WE_N=CE_N=OE_N=1, SRAM_DQ=Z.
- wr_en=1, address=1028, writeData=32'hDEADBEEF (WAIT_CYCLES=2):
  - 2 cycles SRAM_ADDR=2, DQ=16'hBEEF, WE_N=0.
  - then 2 cycles SRAM_ADDR=3, DQ=16'hDEAD.
  - ready low 5 cycles, then high 1 cycle.
- rd_en=1, address=1028, SRAM model preloaded from the previous write -> OE_N=0 for 4 cycles, readData=32'hDEADBEEF when ready rises, ready low exactly 5 cycles.
- wr_en=rd_en=1, address=1032, writeData=32'h12345678 -> write sequence taken, SRAM_ADDR=4 then 5, readData unchanged.
- rst=0 pulsed during RD_HI -> FSM back to IDLE immediately, pins released, readData=0, no DONE cycle.
- SRAM_MISALIGN_CHECK_EN defined, rd_en=1, address=1030 -> misaligned=1 and stays 1, SRAM_ADDR=2/3. Undefined -> misaligned stays 0.

Source files
------------

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : MEM-stage data-memory front end. Maps 32-bit word loads and
//                stores onto an external 256K x 16 asynchronous SRAM using two
//                half-word accesses (low half first, then high half). Each
//                half-word access is held on the pins for WAIT_CYCLES clocks.
//                While an access is in flight `ready` is low; its inverse
//                freezes the rest of the pipeline.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BASE_ADDR    CPU byte address mapped to SRAM word 0
//    WAIT_CYCLES  clocks per half-word access (1..15)
//  Optional feature
//    SRAM_MISALIGN_CHECK_EN  when defined, a request accepted with
//                            address[1:0] != 0 sets the sticky `misaligned`
//                            flag; when undefined the flag is tied to 0.
//  Ports
//    clk          in   pipeline clock, rising edge
//    rst          in   asynchronous reset, active low
//    wr_en        in   store request
//    rd_en        in   load request (wr_en wins if both are set)
//    address      in   32-bit byte address
//    writeData    in   32-bit store data
//    readData     out  last loaded word
//    ready        out  1 = no access in progress
//    misaligned   out  sticky alignment error flag
//    SRAM_DQ      io   16-bit SRAM data bus
//    SRAM_ADDR    out  18-bit SRAM half-word address
//    SRAM_UB_N/LB_N/WE_N/CE_N/OE_N  out  active-low SRAM controls
// ============================================================================
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        misaligned,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR_LO = 3'd1;
    localparam logic [2:0] S_WR_HI = 3'd2;
    localparam logic [2:0] S_RD_LO = 3'd3;
    localparam logic [2:0] S_RD_HI = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE_W   = 32'(BASE_ADDR);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] low_q;
    logic [31:0] rdata_q;

    logic        w_last;
    logic        w_req;
    logic        w_active;
    logic        w_hi;
    logic        w_wr_state;
    logic        w_rd_state;
    logic [31:0] w_off;
    logic [16:0] w_word;
    logic [15:0] w_dq_out;

    // Byte offset from the base, wrapping modulo 2^32; the word index is
    // bits [18:2], which also discards any misalignment in address[1:0].
    assign w_off  = address - BASE_W;
    assign w_word = w_off[18:2];

    // Bits of the offset outside the 17-bit word index are intentionally dropped.
    logic w_unused;
    assign w_unused = &{1'b0, w_off[31:19], w_off[1:0]};

    assign w_last     = (cnt_q == LAST_CNT);
    assign w_req      = wr_en | rd_en;
    assign w_wr_state = (state_q == S_WR_LO) || (state_q == S_WR_HI);
    assign w_rd_state = (state_q == S_RD_LO) || (state_q == S_RD_HI);
    assign w_active   = w_wr_state || w_rd_state;
    assign w_hi       = (state_q == S_WR_HI) || (state_q == S_RD_HI);

    // ------------------------------------------------------------------
    // Next-state and wait counter. The counter runs only inside the LO/HI
    // states and clears on every transition.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    state_d = S_WR_LO;
                end else if (rd_en) begin
                    state_d = S_RD_LO;
                end
            end
            S_WR_LO: begin
                if (w_last) state_d = S_WR_HI;
                else        cnt_d   = cnt_q + 4'd1;
            end
            S_WR_HI: begin
                if (w_last) state_d = S_DONE;
                else        cnt_d   = cnt_q + 4'd1;
            end
            S_RD_LO: begin
                if (w_last) state_d = S_RD_HI;
                else        cnt_d   = cnt_q + 4'd1;
            end
            S_RD_HI: begin
                if (w_last) state_d = S_DONE;
                else        cnt_d   = cnt_q + 4'd1;
            end
            // The request is still asserted here (pipeline frozen on entry),
            // so DONE always returns to IDLE without starting a new access.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            low_q   <= 16'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == S_RD_LO) && w_last) begin
                low_q <= SRAM_DQ;
            end
            if ((state_q == S_RD_HI) && w_last) begin
                rdata_q <= {SRAM_DQ, low_q};
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign readData = rdata_q;

    always_comb begin
        ready = 1'b0;
        case (state_q)
            S_IDLE:  ready = ~w_req;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_ADDR = w_active ? {w_word, w_hi} : 18'd0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = ~w_active;
    assign SRAM_WE_N = ~w_wr_state;
    assign SRAM_OE_N = ~w_rd_state;

    assign w_dq_out = w_hi ? writeData[31:16] : writeData[15:0];
    assign SRAM_DQ  = w_wr_state ? w_dq_out : 16'hzzzz;

`ifdef SRAM_MISALIGN_CHECK_EN
    logic misaligned_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else if ((state_q == S_IDLE) && w_req && (address[1:0] != 2'b00)) begin
            misaligned_q <= 1'b1;
        end
    end

    assign misaligned = misaligned_q;
`else
    assign misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_controller
//  Description : Self-checking bench for sram_controller (WAIT_CYCLES = 2).
//                Transactions come from a vector table; the expected per-cycle
//                pin activity of each one is queued when it is launched and
//                popped/compared cycle by cycle. An SRAM model sits on the
//                bus. Reset-at-start and reset-during-RD_HI are hand-written.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int BASE = 1024;
    localparam int WC   = 2;
`ifdef SRAM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        ready, misaligned;
    wire  [15:0] dq;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData),
        .readData(readData), .ready(ready), .misaligned(misaligned),
        .SRAM_DQ(dq), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    // Asynchronous SRAM model
    logic [15:0] mem [0:262143];
    wire         sram_drive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign dq = sram_drive ? mem[SRAM_ADDR] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= dq;
    end

    typedef struct packed {
        logic        rdy;
        logic        ce_n;
        logic        we_n;
        logic        oe_n;
        logic [17:0] addr;
        logic        chk_dq;
        logic [15:0] dq;
    } pin_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_alo;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    pin_t exp_q[$];

    function automatic pin_t mk(input logic r, input logic c, input logic w,
                                input logic o, input logic [17:0] a,
                                input logic k, input logic [15:0] d);
        pin_t p;
        p.rdy = r; p.ce_n = c; p.we_n = w; p.oe_n = o;
        p.addr = a; p.chk_dq = k; p.dq = d;
        return p;
    endfunction

    task automatic chk_pins(input string nm, input pin_t e);
        pin_t a;
        a = mk(ready, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_ADDR,
               e.chk_dq, e.chk_dq ? dq : 16'h0);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got rdy=%b ce_n=%b we_n=%b oe_n=%b addr=%h dq=%h, want rdy=%b ce_n=%b we_n=%b oe_n=%b addr=%h dq=%h",
                     nm, a.rdy, a.ce_n, a.we_n, a.oe_n, a.addr, a.dq,
                     e.rdy, e.ce_n, e.we_n, e.oe_n, e.addr, e.dq);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Launch one transaction from IDLE and follow it through DONE.
    task automatic run_txn(input int idx, input vec_t v);
        pin_t p;
        logic isw;
        isw = v.wr;
        exp_q.delete();
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0, 16'h0));
        for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < WC; c++) begin
                exp_q.push_back(mk(1'b0, 1'b0, ~isw, isw, v.exp_alo + 18'(h), isw,
                                   isw ? (h == 0 ? v.wdata[15:0] : v.wdata[31:16]) : 16'h0));
            end
        end
        exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0, 16'h0));

        @(negedge clk);
        wr_en = v.wr; rd_en = v.rd; address = v.addr; writeData = v.wdata;
        #1;
        while (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            chk_pins($sformatf("v%0d_cyc", idx), p);
            if (exp_q.size() > 0) begin
                @(negedge clk); #1;
            end
        end
        chk32($sformatf("v%0d_rdata", idx), readData, v.exp_rdata);
        chk32($sformatf("v%0d_mis", idx), {31'd0, misaligned}, {31'd0, v.exp_mis});
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk); #1;
        chk_pins($sformatf("v%0d_idle", idx), mk(1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0, 16'h0));
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        mem[200] = 16'h5A5A;
        mem[201] = 16'hC3C3;

        //          wr    rd    address  wdata          lo-addr    readData after  misaligned
        vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2,     32'h00000000,  1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'd2,     32'hDEADBEEF,  1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 18'd4,     32'hDEADBEEF,  1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd1032, 32'h0,        18'd4,     32'h12345678,  1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'd1424, 32'h0,        18'd200,   32'hC3C35A5A,  1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 32'hC3C35A5A,  1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'h0,        18'h3FFFE, 32'hCAFEF00D,  1'b0};
        vecs[7] = '{1'b0, 1'b1, 32'd1030, 32'h0,        18'd2,     32'hDEADBEEF,  MIS_EN};

        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; writeData = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk_pins("reset_pins", mk(1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0, 16'h0));
        chk32("reset_rdata", readData, 32'd0);
        chk32("reset_misc", {29'd0, misaligned, SRAM_UB_N, SRAM_LB_N}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // Misaligned flag must be sticky across a later aligned access.
        run_txn(8, '{1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF, MIS_EN});

        // Reset during RD_HI abandons the read without a DONE cycle.
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1028;
        repeat (3) @(negedge clk);
        #1;
        chk_pins("rst_pre_rdhi", mk(1'b0, 1'b0, 1'b1, 1'b0, 18'd3, 1'b0, 16'h0));
        rst = 1'b0;
        #1;
        chk_pins("rst_mid_pins", mk(1'b0, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0, 16'h0));
        chk32("rst_mid_rdata", readData, 32'd0);
        chk32("rst_mid_mis", {31'd0, misaligned}, 32'd0);
        rd_en = 1'b0;
        #1;
        chk_pins("rst_mid_idle", mk(1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0, 16'h0));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk_pins($sformatf("post_rst_idle%0d", k), mk(1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 1'b0, 16'h0));
            chk32($sformatf("post_rst_rdata%0d", k), readData, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
